// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: runs wide-word ops on a 6-bit ALU,
// one chunk per clock, least-significant chunk first.
module alu_word_sequencer #(
  parameter int N_CHUNKS = 4,
  parameter int CW       = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic                    cmd_carry_in,
  input  logic                    cmd_chain,
  input  logic [6*N_CHUNKS-1:0]   cmd_a,
  input  logic [6*N_CHUNKS-1:0]   cmd_b,
  input  logic                    cmd_abort,
  output logic [3:0]              alu_op,
  output logic                    alu_carry_in,
  output logic [5:0]              alu_a,
  output logic [5:0]              alu_b,
  input  logic [5:0]              alu_result,
  input  logic                    alu_carry_out,
  output logic                    busy,
  output logic                    done,
  output logic [6*N_CHUNKS-1:0]   res,
  output logic                    res_carry_out,
  output logic                    res_zero
);

  localparam int W = 6 * N_CHUNKS;
  localparam logic [CW-1:0] LAST = CW'(N_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t        state, stateNext;
  logic [CW-1:0] chunkIdx;
  logic          carryReg;
  logic          chainReg;
  logic          cinReg;
  logic [3:0]    opReg;
  logic [W-1:0]  aReg, bReg;
  logic [W-1:0]  resReg, resNext;
  logic [5:0]    aChunk, bChunk;
  logic          carryOutReg;
  logic          zeroReg;
  logic          accept;
  logic          step;
  logic          lastChunk;

  // abort wins over a same-cycle request in IDLE
  assign accept    = (state == IDLE) & cmd_valid & ~cmd_abort;
  assign step      = (state == EXEC) & ~cmd_abort;
  assign lastChunk = (chunkIdx == LAST);

  always_comb begin
    aChunk  = '0;
    bChunk  = '0;
    resNext = resReg;
    for (int i = 0; i < N_CHUNKS; i++) begin
      if (chunkIdx == CW'(i)) begin
        aChunk              = aReg[6*i +: 6];
        bChunk              = bReg[6*i +: 6];
        resNext[6*i +: 6]   = alu_result;
      end
    end
  end

  always_comb begin
    stateNext    = state;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    alu_op       = '0;
    alu_a        = '0;
    alu_b        = '0;
    alu_carry_in = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept) stateNext = EXEC;
      end
      EXEC: begin
        busy         = 1'b1;
        alu_op       = opReg;
        alu_a        = aChunk;
        alu_b        = bChunk;
        alu_carry_in = chainReg ? carryReg : cinReg;
        if (cmd_abort)      stateNext = IDLE;
        else if (lastChunk) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunkIdx    <= '0;
      carryReg    <= 1'b0;
      chainReg    <= 1'b0;
      cinReg      <= 1'b0;
      opReg       <= '0;
      aReg        <= '0;
      bReg        <= '0;
      resReg      <= '0;
      carryOutReg <= 1'b0;
      zeroReg     <= 1'b1;
    end else if (accept) begin
      chunkIdx <= '0;
      carryReg <= cmd_carry_in;
      chainReg <= cmd_chain;
      cinReg   <= cmd_carry_in;
      opReg    <= cmd_op;
      aReg     <= cmd_a;
      bReg     <= cmd_b;
    end else if (step) begin
      resReg   <= resNext;
      carryReg <= alu_carry_out;
      if (lastChunk) begin
        chunkIdx    <= '0;
        carryOutReg <= alu_carry_out;
        zeroReg     <= (resNext == '0);
      end else begin
        chunkIdx <= chunkIdx + 1'b1;
      end
    end
  end

  assign res           = resReg;
  assign res_carry_out = carryOutReg;
  assign res_zero      = zeroReg;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// tb_alu_word_sequencer: random and directed commands checked
// against a word-level reference model, with a 6-bit ALU model.
module tb_alu_word_sequencer;

  localparam int N  = 4;
  localparam int W  = 6 * N;
  localparam int W1 = W + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic         cmd_carry_in;
  logic         cmd_chain;
  logic [W-1:0] cmd_a, cmd_b;
  logic         cmd_abort;
  logic [3:0]   alu_op;
  logic         alu_carry_in;
  logic [5:0]   alu_a, alu_b;
  logic [5:0]   alu_result;
  logic         alu_carry_out;
  logic         busy, done;
  logic [W-1:0] res;
  logic         res_carry_out;
  logic         res_zero;

  int checks = 0;
  int errors = 0;

  alu_word_sequencer #(.N_CHUNKS(N), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_carry_in(cmd_carry_in),
    .cmd_chain(cmd_chain), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_abort(cmd_abort),
    .alu_op(alu_op), .alu_carry_in(alu_carry_in),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .busy(busy), .done(done), .res(res),
    .res_carry_out(res_carry_out), .res_zero(res_zero)
  );

  always #5 clk = ~clk;

  // 6-bit ripple ALU stand-in
  logic [6:0] aluSum;
  always_comb begin
    aluSum = '0;
    case (alu_op)
      OP_ADD: aluSum = {1'b0, alu_a} + {1'b0, alu_b} + 7'(alu_carry_in);
      OP_SUB: aluSum = {1'b0, alu_a} + {1'b0, ~alu_b} + 7'(alu_carry_in);
      OP_AND: aluSum = {1'b0, alu_a & alu_b};
      OP_OR:  aluSum = {1'b0, alu_a | alu_b};
      OP_XOR: aluSum = {1'b0, alu_a ^ alu_b};
      default: aluSum = '0;
    endcase
  end
  assign alu_result    = aluSum[5:0];
  assign alu_carry_out = aluSum[6];

  // returns {carry, result} for a whole command
  function automatic logic [W:0] refOp(
    input logic [3:0] op, input logic chain, input logic cin,
    input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   r;
    logic [W-1:0] bb;
    logic [6:0]   s;
    r  = '0;
    bb = (op == OP_SUB) ? ~b : b;
    case (op)
      OP_AND: r = {1'b0, a & b};
      OP_OR:  r = {1'b0, a | b};
      OP_XOR: r = {1'b0, a ^ b};
      OP_ADD, OP_SUB: begin
        if (chain) begin
          r = {1'b0, a} + {1'b0, bb} + W1'(cin);
        end else begin
          for (int k = 0; k < N; k++) begin
            s = {1'b0, a[6*k +: 6]} + {1'b0, bb[6*k +: 6]} + 7'(cin);
            r[6*k +: 6] = s[5:0];
            r[W]        = s[6];
          end
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic driveCmd(input logic [3:0] op, input logic chain,
                          input logic cin, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_chain    = chain;
    cmd_carry_in = cin;
    cmd_a        = a;
    cmd_b        = b;
  endtask

  // waits at negedges for done; returns cycles and busy count
  task automatic waitDone(output int cyc, output int busyCyc,
                          input logic [5:0] a0, input logic [3:0] op);
    cyc = 0;
    busyCyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) busyCyc++;
      if (cyc == 1) begin
        check("alu_a0", 32'(alu_a), 32'(a0));
        check("alu_op", 32'(alu_op), 32'(op));
      end
    end
  endtask

  task automatic checkResult(input string tag, input logic [W:0] exp,
                             input int cyc, input int busyCyc);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".lat"}, cyc, N + 1);
    check({tag, ".busy"}, busyCyc, N);
    check({tag, ".res"}, 32'(res), 32'(exp[W-1:0]));
    check({tag, ".cout"}, 32'(res_carry_out), 32'(exp[W]));
    check({tag, ".zero"}, 32'(res_zero), 32'(exp[W-1:0] == '0));
    check({tag, ".rdy"}, 32'(cmd_ready), 32'd0);
  endtask

  task automatic runCmd(input string tag, input logic [3:0] op,
                        input logic chain, input logic cin,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] exp;
    int cyc, busyCyc;
    exp = refOp(op, chain, cin, a, b);
    @(negedge clk);
    check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    driveCmd(op, chain, cin, a, b);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    waitDone(cyc, busyCyc, a[5:0], op);
    checkResult(tag, exp, cyc, busyCyc);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W:0] exp;
    logic [3:0] op;
    int cyc, busyCyc, doneSeen;

    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_op       = '0;
    cmd_carry_in = 1'b0;
    cmd_chain    = 1'b0;
    cmd_a        = '0;
    cmd_b        = '0;
    cmd_abort    = 1'b0;
    #12;
    check("rst.res", 32'(res), 32'd0);
    check("rst.zero", 32'(res_zero), 32'd1);
    check("rst.cout", 32'(res_carry_out), 32'd0);
    check("rst.ready", 32'(cmd_ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runCmd("chain", OP_ADD, 1'b1, 1'b0, 24'h00003F, 24'h000001);
    check("chain.lit", 32'(res), 32'h40);
    runCmd("wrap", OP_ADD, 1'b1, 1'b0, 24'hFFFFFF, 24'h000001);
    check("wrap.lit", 32'(res_carry_out), 32'd1);
    runCmd("unch", OP_ADD, 1'b0, 1'b0, 24'h00003F, 24'h000001);

    // abort in the 2nd EXEC cycle
    @(negedge clk);
    driveCmd(OP_ADD, 1'b1, 1'b0, 24'hFFFFFF, 24'h000001);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmd_abort = 1'b1;
    @(posedge clk);
    #1 cmd_abort = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.ready", 32'(cmd_ready), 32'd1);
    check("abort.chunk0", 32'(res[5:0]), 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    check("abort.nodone", doneSeen, 0);
    runCmd("postabort", OP_SUB, 1'b1, 1'b1, 24'h123456, 24'h012345);

    // abort in IDLE blocks the accept
    @(negedge clk);
    driveCmd(OP_ADD, 1'b1, 1'b0, 24'h1, 24'h1);
    cmd_abort = 1'b1;
    @(posedge clk);
    #1;
    check("idleabort.ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    cmd_abort = 1'b0;

    // reset in the 3rd EXEC cycle
    @(negedge clk);
    driveCmd(OP_ADD, 1'b1, 1'b0, 24'hFFFFFF, 24'h000001);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.res", 32'(res), 32'd0);
    check("rstmid.zero", 32'(res_zero), 32'd1);
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    check("rstmid.nodone", doneSeen, 0);

    // cmd_valid held through EXEC/DONE with a different operand
    @(negedge clk);
    driveCmd(OP_ADD, 1'b1, 1'b0, 24'h123456, 24'h0F0F0F);
    exp = refOp(OP_ADD, 1'b1, 1'b0, 24'h123456, 24'h0F0F0F);
    @(posedge clk);
    #1 cmd_a = 24'hABCDEF;
    waitDone(cyc, busyCyc, 6'h16, OP_ADD);
    checkResult("hold1", exp, cyc, busyCyc);
    @(negedge clk);
    check("hold.ready", 32'(cmd_ready), 32'd1);
    exp = refOp(OP_ADD, 1'b1, 1'b0, 24'hABCDEF, 24'h0F0F0F);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    waitDone(cyc, busyCyc, 6'h2F, OP_ADD);
    checkResult("hold2", exp, cyc, busyCyc);

    for (int t = 0; t < 40; t++) begin
      op = 4'($urandom_range(0, 4));
      runCmd("rand", op, 1'($urandom), 1'($urandom),
             W'($urandom), W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
